// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file with scoreboard.
package regfile_pkg;

  localparam int REG_W    = 32;
  localparam int REG_AW   = 5;
  localparam int REG_N    = 32;
  localparam int ZERO_REG = 0;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_W-1:0]  reg_data_t;

  // One-hot decode of a register address into an REG_N-wide vector.
  function automatic logic [REG_N-1:0] onehot_addr(input reg_addr_t addr);
    logic [REG_N-1:0] vec;
    vec = {REG_N{1'b0}};
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux32to1_n.sv
// Library m:1 multiplexer of n-bit words selected by an address-bit index.
// Input words are packed little-endian: word i occupies data_i[i*n +: n].
module mux32to1_n #(
  parameter int n       = 32,
  parameter int address = 5,
  parameter int m       = 32
) (
  input  logic [m*n-1:0]     data_i,
  input  logic [address-1:0] sel_i,
  output logic [n-1:0]       data_o
);

  // Select the addressed word; an out-of-range select yields zero.
  always_comb begin
    data_o = {n{1'b0}};
    for (int i = 0; i < m; i++) begin
      if (sel_i == address'(i)) begin
        data_o = data_i[i*n +: n];
      end else begin
        data_o = data_o;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write integer register file with a pending-write scoreboard.
// Register 0 reads zero and is never busy. Reads are combinational with a
// same-cycle write-back bypass; stall_o flags RAW/WAW hazards for decode.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int n       = REG_W,
  parameter int address = REG_AW,
  parameter int m       = REG_N
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [address-1:0] rs1_addr_i,
  input  logic [address-1:0] rs2_addr_i,
  output logic [n-1:0]       rs1_data_o,
  output logic [n-1:0]       rs2_data_o,
  input  logic               we_i,
  input  logic [address-1:0] rd_addr_i,
  input  logic [n-1:0]       rd_data_i,
  input  logic               issue_i,
  input  logic [address-1:0] issue_rd_i,
  output logic               stall_o
);

  localparam logic [address-1:0] ZERO_ADDR = address'(ZERO_REG);

  // Architectural state.
  logic [n-1:0]   regs_q [m];
  logic [m-1:0]   busy_q;
  logic [m-1:0]   busy_d;

  // Combinational helpers.
  logic [m*n-1:0] regs_flat_s;
  logic [n-1:0]   rs1_arr_s;
  logic [n-1:0]   rs2_arr_s;
  logic           wr_en_s;
  logic           rs1_byp_s;
  logic           rs2_byp_s;
  logic           rs1_hit_s;
  logic           rs2_hit_s;
  logic           waw_s;
  logic           stall_s;
  logic           accept_s;
  logic [m-1:0]   clr_vec_s;
  logic [m-1:0]   set_vec_s;

  // A write-back to x0 is dropped so the zero register never changes.
  assign wr_en_s = we_i && (rd_addr_i != ZERO_ADDR);

  // Bypass only a real write-back whose destination matches the read address.
  assign rs1_byp_s = wr_en_s && (rd_addr_i == rs1_addr_i);
  assign rs2_byp_s = wr_en_s && (rd_addr_i == rs2_addr_i);

  // Flatten the array so it can feed the library read multiplexers.
  always_comb begin
    regs_flat_s = {(m*n){1'b0}};
    for (int i = 0; i < m; i++) begin
      regs_flat_s[i*n +: n] = regs_q[i];
    end
  end

  mux32to1_n #(
    .n       (n),
    .address (address),
    .m       (m)
  ) u_rs1_mux (
    .data_i  (regs_flat_s),
    .sel_i   (rs1_addr_i),
    .data_o  (rs1_arr_s)
  );

  mux32to1_n #(
    .n       (n),
    .address (address),
    .m       (m)
  ) u_rs2_mux (
    .data_i  (regs_flat_s),
    .sel_i   (rs2_addr_i),
    .data_o  (rs2_arr_s)
  );

  // Read port 1: zero during reset and for x0, else bypass or stored value.
  always_comb begin
    if (rst_i || (rs1_addr_i == ZERO_ADDR)) begin
      rs1_data_o = {n{1'b0}};
    end else if (rs1_byp_s) begin
      rs1_data_o = rd_data_i;
    end else begin
      rs1_data_o = rs1_arr_s;
    end
  end

  // Read port 2: zero during reset and for x0, else bypass or stored value.
  always_comb begin
    if (rst_i || (rs2_addr_i == ZERO_ADDR)) begin
      rs2_data_o = {n{1'b0}};
    end else if (rs2_byp_s) begin
      rs2_data_o = rd_data_i;
    end else begin
      rs2_data_o = rs2_arr_s;
    end
  end

  // A write-back arriving this cycle resolves a hazard on its destination.
  assign rs1_hit_s = busy_q[rs1_addr_i] && !(we_i && (rd_addr_i == rs1_addr_i));
  assign rs2_hit_s = busy_q[rs2_addr_i] && !(we_i && (rd_addr_i == rs2_addr_i));
  assign waw_s     = busy_q[issue_rd_i] && !(we_i && (rd_addr_i == issue_rd_i));

  assign stall_s  = !rst_i && issue_i && (rs1_hit_s || rs2_hit_s || waw_s);
  assign stall_o  = stall_s;
  assign accept_s = issue_i && !stall_s && (issue_rd_i != ZERO_ADDR);

  // Busy next state: clear on write-back, then set on accepted issue so a
  // newly issued producer wins over a same-cycle write-back to that register.
  always_comb begin
    clr_vec_s = we_i     ? onehot_addr(REG_AW'(rd_addr_i))  : {m{1'b0}};
    set_vec_s = accept_s ? onehot_addr(REG_AW'(issue_rd_i)) : {m{1'b0}};
    busy_d    = (busy_q & ~clr_vec_s) | set_vec_s;
    busy_d[0] = 1'b0;
  end

  // Busy vector register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= {m{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register array: cleared on reset, loaded by a non-x0 write-back otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < m; i++) begin
        regs_q[i] <= {n{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_q[rd_addr_i] <= rd_data_i;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized
// run compared against an array/scoreboard reference model.
module tb_regfile_sb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, issue_rd_i;
  logic [31:0] rs1_data_o, rs2_data_o, rd_data_i;
  logic        we_i, issue_i, stall_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_regs [32];
  logic        ref_busy [32];

  regfile_sb #(.n(32), .address(5), .m(32)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o),
    .we_i       (we_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .issue_i    (issue_i),
    .issue_rd_i (issue_rd_i),
    .stall_o    (stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected read value from the architectural model.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (rst_i) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (we_i && rd_addr_i == a) return rd_data_i;
    return ref_regs[a];
  endfunction

  // Expected stall from the scoreboard model.
  function automatic logic exp_stall();
    logic h1, h2, w;
    if (rst_i) return 1'b0;
    h1 = ref_busy[rs1_addr_i] && !(we_i && rd_addr_i == rs1_addr_i);
    h2 = ref_busy[rs2_addr_i] && !(we_i && rd_addr_i == rs2_addr_i);
    w  = ref_busy[issue_rd_i] && !(we_i && rd_addr_i == issue_rd_i);
    return issue_i && (h1 || h2 || w);
  endfunction

  task automatic set_in(input logic rst, input logic we, input logic [4:0] rd,
                        input logic [31:0] data, input logic iss, input logic [4:0] ird,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    rst_i = rst; we_i = we; rd_addr_i = rd; rd_data_i = data;
    issue_i = iss; issue_rd_i = ird; rs1_addr_i = rs1; rs2_addr_i = rs2;
    #1;
  endtask

  // Advance the model with the current inputs, then let the DUT clock.
  task automatic clk_edge();
    logic s;
    s = exp_stall();
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        ref_regs[i] = 32'd0;
        ref_busy[i] = 1'b0;
      end
    end else begin
      if (we_i && rd_addr_i != 5'd0) ref_regs[rd_addr_i] = rd_data_i;
      if (we_i) ref_busy[rd_addr_i] = 1'b0;
      if (issue_i && !s && issue_rd_i != 5'd0) ref_busy[issue_rd_i] = 1'b1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    set_in(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF, 1'b1, 5'd5, 5'd5, 5'd5);
    n_vec++;
    if (rs1_data_o !== 32'd0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL rst_during: rs1=%h stall=%b expected 0/0", rs1_data_o, stall_o);
    end
    clk_edge();
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(a), 5'(31 - a));
      n_vec++;
      if (rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0) begin
        n_err++; $display("FAIL rst_read a=%0d: rs1=%h rs2=%h expected 0", a, rs1_data_o, rs2_data_o);
      end
      clk_edge();
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd12, 5'd13);
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL rst_stall: got %b expected 0", stall_o);
    end
    clk_edge();
    set_in(1'b0, 1'b1, 5'd11, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    clk_edge();
  endtask

  task automatic test_write_read();
    set_in(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    n_vec++;
    if (rs1_data_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL wr_rd_rs1: got %h expected %h", rs1_data_o, 32'hDEAD_BEEF);
    end
    n_vec++;
    if (rs2_data_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL wr_rd_rs2: got %h expected %h", rs2_data_o, 32'hDEAD_BEEF);
    end
    set_in(1'b0, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 5'd5);
    n_vec++;
    if (rs1_data_o !== 32'd0) begin
      n_err++; $display("FAIL x0_bypass: got %h expected 0", rs1_data_o);
    end
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    n_vec++;
    if (rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0) begin
      n_err++; $display("FAIL x0_read: rs1=%h rs2=%h expected 0", rs1_data_o, rs2_data_o);
    end
  endtask

  task automatic test_bypass();
    set_in(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd7, 5'd5);
    n_vec++;
    if (rs1_data_o !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL bypass_rs1: got %h expected %h", rs1_data_o, 32'hA5A5_A5A5);
    end
    n_vec++;
    if (rs2_data_o !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL bypass_other: got %h expected %h", rs2_data_o, 32'hDEAD_BEEF);
    end
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd7);
    n_vec++;
    if (rs2_data_o !== 32'hA5A5_A5A5) begin
      n_err++; $display("FAIL bypass_stored: got %h expected %h", rs2_data_o, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_raw_stall();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL raw_issue: got %b expected 0", stall_o);
    end
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd3, 5'd0);
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++; $display("FAIL raw_stall: got %b expected 1", stall_o);
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0);
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL raw_noissue: got %b expected 0", stall_o);
    end
    clk_edge();
    set_in(1'b0, 1'b1, 5'd3, 32'h1357_2468, 1'b1, 5'd0, 5'd3, 5'd0);
    n_vec++;
    if (stall_o !== 1'b0 || rs1_data_o !== 32'h1357_2468) begin
      n_err++; $display("FAIL raw_resolve: stall=%b rs1=%h expected 0/%h", stall_o, rs1_data_o, 32'h1357_2468);
    end
    clk_edge();
  endtask

  task automatic test_waw();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0);
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++; $display("FAIL waw_stall: got %b expected 1", stall_o);
    end
    clk_edge();
    set_in(1'b0, 1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9, 5'd0, 5'd0);
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL waw_simul: got %b expected 0", stall_o);
    end
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd9, 5'd0);
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++; $display("FAIL waw_set_wins: got %b expected 1", stall_o);
    end
    set_in(1'b0, 1'b1, 5'd9, 32'h0000_0999, 1'b0, 5'd0, 5'd0, 5'd0);
    clk_edge();
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd4, 5'd0, 5'd0);
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd0, 5'd0);
    clk_edge();
    set_in(1'b1, 1'b1, 5'd4, 32'hFFFF_0000, 1'b1, 5'd8, 5'd4, 5'd6);
    n_vec++;
    if (rs1_data_o !== 32'd0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_during: rs1=%h stall=%b expected 0/0", rs1_data_o, stall_o);
    end
    clk_edge();
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd6, 5'd4);
    n_vec++;
    if (rs2_data_o !== 32'd0) begin
      n_err++; $display("FAIL midrst_x4: got %h expected 0", rs2_data_o);
    end
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_stall: got %b expected 0", stall_o);
    end
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd5, 5'd7);
    n_vec++;
    if (rs1_data_o !== 32'd0 || rs2_data_o !== 32'd0 || stall_o !== 1'b0) begin
      n_err++; $display("FAIL midrst_clear: rs1=%h rs2=%h stall=%b expected 0/0/0", rs1_data_o, rs2_data_o, stall_o);
    end
    clk_edge();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    logic        es;
    for (int c = 0; c < 600; c++) begin
      set_in(($urandom_range(0, 63) == 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
             $urandom(),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
      e1 = exp_read(rs1_addr_i);
      e2 = exp_read(rs2_addr_i);
      es = exp_stall();
      n_vec++;
      if (rs1_data_o !== e1) begin
        n_err++; $display("FAIL rand_rs1 c=%0d a=%0d: got %h expected %h", c, rs1_addr_i, rs1_data_o, e1);
      end
      n_vec++;
      if (rs2_data_o !== e2) begin
        n_err++; $display("FAIL rand_rs2 c=%0d a=%0d: got %h expected %h", c, rs2_addr_i, rs2_data_o, e2);
      end
      n_vec++;
      if (stall_o !== es) begin
        n_err++; $display("FAIL rand_stall c=%0d: got %b expected %b", c, stall_o, es);
      end
      clk_edge();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_regs[i] = 32'd0;
      ref_busy[i] = 1'b0;
    end
    set_in(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    clk_edge();
    test_reset();
    test_write_read();
    test_bypass();
    test_raw_stall();
    test_waw();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
